// File: rtl/wb_gpio_irq.sv
// wb_gpio_irq: Wishbone classic GPIO slave with set/clear outputs and per-pin interrupts.
// Ports:
//   wb_clk, wb_rst            clock, synchronous active-high reset
//   wb_adr_i..wb_bte_i        Wishbone slave request (cti/bte accepted but ignored)
//   wb_dat_o/ack_o/err_o/rty_o Wishbone response (registered, one cycle after request)
//   gpio_i                    asynchronous pad inputs
//   gpio_o, gpio_dir_o        output data and output-enable (1 = drive)
//   irq_o                     registered interrupt request, active high
module wb_gpio_irq #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic [3:0]       wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  input  logic [3:0]       wb_sel_i,
  input  logic             wb_we_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic [2:0]       wb_cti_i,
  input  logic [1:0]       wb_bte_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  output logic             wb_err_o,
  output logic             wb_rty_o,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_dir_o,
  output logic             irq_o
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] PRIME_N = CNT_W'(SYNC_STAGES + 1);

  localparam logic [3:0] A_IN    = 4'h0;
  localparam logic [3:0] A_OUT   = 4'h1;
  localparam logic [3:0] A_DIR   = 4'h2;
  localparam logic [3:0] A_SET   = 4'h3;
  localparam logic [3:0] A_CLR   = 4'h4;
  localparam logic [3:0] A_EN    = 4'h5;
  localparam logic [3:0] A_TYPE  = 4'h6;
  localparam logic [3:0] A_POL   = 4'h7;
  localparam logic [3:0] A_BOTH  = 4'h8;
  localparam logic [3:0] A_STAT  = 4'h9;

  logic [WIDTH-1:0] out_q, out_d, dir_q, dir_d, en_q, en_d;
  logic [WIDTH-1:0] type_q, type_d, pol_q, pol_d, both_q, both_d;
  logic [WIDTH-1:0] stat_q, stat_d, prev_q;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ack_q, ack_d, err_q, err_d, irq_q, irq_d;
  logic [31:0]      dat_q, dat_d;

  logic [31:0]      bmask32, rdata;
  logic [WIDTH-1:0] wdat, wmsk, sync, rise, fall, lvl_evt, edge_evt, evt, clr;
  logic             req, mapped, wr, primed;

  // Inputs that carry no meaning for a classic single-beat slave.
  logic unused_ok;
  assign unused_ok = ^{wb_cti_i, wb_bte_i};

  // Next-state: bus decode, register writes, event detection and sticky status.
  always_comb begin
    bmask32 = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    wdat    = WIDTH'(wb_dat_i & bmask32);
    wmsk    = WIDTH'(bmask32);
    req     = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
    mapped  = (wb_adr_i <= A_STAT);
    wr      = req & wb_we_i & mapped;
    primed  = (cnt_q == PRIME_N);
    sync    = sync_q[SYNC_STAGES-1];

    out_d  = out_q;
    dir_d  = dir_q;
    en_d   = en_q;
    type_d = type_q;
    pol_d  = pol_q;
    both_d = both_q;
    clr    = '0;

    if (wr) begin
      case (wb_adr_i)
        A_OUT:   out_d  = (out_q  & ~wmsk) | wdat;
        A_DIR:   dir_d  = (dir_q  & ~wmsk) | wdat;
        A_SET:   out_d  = out_q | wdat;
        A_CLR:   out_d  = out_q & ~wdat;
        A_EN:    en_d   = (en_q   & ~wmsk) | wdat;
        A_TYPE:  type_d = (type_q & ~wmsk) | wdat;
        A_POL:   pol_d  = (pol_q  & ~wmsk) | wdat;
        A_BOTH:  both_d = (both_q & ~wmsk) | wdat;
        A_STAT:  clr    = wdat;
        default: ;
      endcase
    end

    // Both level and edge events are held off until the sync chain and prev hold real pin data.
    rise     = sync & ~prev_q;
    fall     = ~sync & prev_q;
    lvl_evt  = ~(sync ^ pol_q);
    edge_evt = (both_q & (rise | fall)) | (~both_q & ((pol_q & rise) | (~pol_q & fall)));
    evt      = primed ? ((type_q & edge_evt) | (~type_q & lvl_evt)) : '0;

    // A new event wins over a coincident clear.
    stat_d = (stat_q & ~clr) | evt;
    irq_d  = |(stat_q & en_q);
    cnt_d  = primed ? cnt_q : cnt_q + CNT_W'(1);

    case (wb_adr_i)
      A_IN:    rdata = 32'(sync);
      A_OUT:   rdata = 32'(out_q);
      A_DIR:   rdata = 32'(dir_q);
      A_EN:    rdata = 32'(en_q);
      A_TYPE:  rdata = 32'(type_q);
      A_POL:   rdata = 32'(pol_q);
      A_BOTH:  rdata = 32'(both_q);
      A_STAT:  rdata = 32'(stat_q);
      default: rdata = 32'd0;
    endcase

    ack_d = req & mapped;
    err_d = req & ~mapped;
    dat_d = (req & mapped & ~wb_we_i) ? rdata : 32'd0;
  end

  // State registers.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      out_q  <= '0;
      dir_q  <= '0;
      en_q   <= '0;
      type_q <= '0;
      pol_q  <= '0;
      both_q <= '0;
      stat_q <= '0;
      prev_q <= '0;
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
      cnt_q  <= '0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      dat_q  <= 32'd0;
      irq_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      dir_q  <= dir_d;
      en_q   <= en_d;
      type_q <= type_d;
      pol_q  <= pol_d;
      both_q <= both_d;
      stat_q <= stat_d;
      prev_q <= sync;
      sync_q[0] <= gpio_i;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      cnt_q  <= cnt_d;
      ack_q  <= ack_d;
      err_q  <= err_d;
      dat_q  <= dat_d;
      irq_q  <= irq_d;
    end
  end

  assign wb_dat_o   = dat_q;
  assign wb_ack_o   = ack_q;
  assign wb_err_o   = err_q;
  assign wb_rty_o   = 1'b0;
  assign gpio_o     = out_q;
  assign gpio_dir_o = dir_q;
  assign irq_o      = irq_q;

endmodule
